// File: rtl/simplez_pkg.sv
// Shared SIMPLEZ definitions: memory-mapped I/O addresses, opcodes and the
// transmitter state encoding.
package simplez_pkg;

    localparam logic [8:0] ADDR_LEDS = 9'o100;
    localparam logic [8:0] ADDR_DATA = 9'o101;
    localparam logic [8:0] ADDR_STAT = 9'o102;

    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Status word low bits as seen by a CPU load from the STAT address.
    function automatic logic [2:0] stat_bits(input logic ovr, input logic busy,
                                             input logic hold_full);
        return {ovr, busy, ~hold_full};
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the transmitter; held at zero while disabled so
// every frame starts on a fresh bit boundary.
module uart_baud_gen #(
    parameter int unsigned BAUD_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bit_end
);

    localparam int unsigned CNTW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CNTW-1:0] cnt;

    assign bit_end = enable && (cnt == CNTW'(BAUD_DIV - 1));

    always_ff @(negedge clk) begin
        if (rst || !enable) begin
            cnt <= '0;
        end else if (bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNTW'(1);
        end
    end

endmodule

// File: rtl/simplez_uart_tx.sv
// Memory-mapped 8N1 serial transmitter on the SIMPLEZ data bus: one holding
// register in front of a shift register, with a sticky overrun flag.
module simplez_uart_tx #(
    parameter int unsigned      DATAW     = 12,
    parameter int unsigned      ADDRW     = 9,
    parameter int unsigned      BAUD_DIV  = 104,
    parameter logic [ADDRW-1:0] ADDR_DATA = simplez_pkg::ADDR_DATA,
    parameter logic [ADDRW-1:0] ADDR_STAT = simplez_pkg::ADDR_STAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADDRW-1:0] addr,
    input  logic             wr,
    input  logic [DATAW-1:0] din,
    output logic [DATAW-1:0] dout,
    output logic             sel,
    output logic             tx,
    output logic             busy
);

    import simplez_pkg::*;

    tx_state_t  state;
    logic [7:0] hold;
    logic       hold_full;
    logic       ovr;
    logic [7:0] shreg;
    logic [2:0] bitidx;
    logic       bit_end;

    logic hit_data;
    logic hit_stat;
    logic wr_data;
    logic wr_stat;
    logic load;

    logic unused_din_hi;
    assign unused_din_hi = ^din[DATAW-1:8];

    assign hit_data = (addr == ADDR_DATA);
    assign hit_stat = (addr == ADDR_STAT);
    assign sel      = hit_data || hit_stat;
    assign wr_data  = wr && hit_data;
    assign wr_stat  = wr && hit_stat;
    assign busy     = (state != S_IDLE);

    // The shifter empties the holding register on the same edge a new byte
    // may arrive, so a write coinciding with a load is still accepted.
    assign load = (state == S_IDLE) && hold_full;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .enable  (busy),
        .bit_end (bit_end)
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx        <= 1'b1;
            hold      <= '0;
            hold_full <= 1'b0;
            ovr       <= 1'b0;
            shreg     <= '0;
            bitidx    <= '0;
        end else begin
            // tx follows the state one edge later, giving a clean registered line
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (hold_full) begin
                        shreg <= hold;
                        state <= S_START;
                    end
                end
                S_START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        state  <= S_DATA;
                        bitidx <= '0;
                    end
                end
                S_DATA: begin
                    tx <= shreg[0];
                    if (bit_end) begin
                        shreg <= {1'b0, shreg[7:1]};
                        if (bitidx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bitidx <= bitidx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase

            if (wr_data) begin
                if (!hold_full || load) begin
                    hold      <= din[7:0];
                    hold_full <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (wr_stat) begin
                ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        dout = '0;
        if (hit_stat) begin
            dout[2:0] = stat_bits(ovr, busy, hold_full);
        end else if (hit_data) begin
            dout[7:0] = hold;
        end
    end

endmodule

// File: tb/tb_simplez_uart_tx.sv
// Self-checking bench for simplez_uart_tx: timing-rule reference model for a
// fast-baud instance plus a sampling receiver on a full-rate instance.
module tb_simplez_uart_tx;

    localparam int B  = 4;
    localparam int BF = 104;
    localparam logic [8:0] A_LEDS = 9'o100;
    localparam logic [8:0] A_DATA = 9'o101;
    localparam logic [8:0] A_STAT = 9'o102;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  addr, addr2;
    logic        wr, wr2;
    logic [11:0] din, din2, dout, dout2;
    logic        sel, sel2, tx, tx2, busy, busy2;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    // Reference model: one record per accepted byte (write edge, load edge, value)
    int         m_w[$];
    int         m_l[$];
    logic [7:0] m_b[$];
    logic       m_ovr;
    logic [7:0] m_hold;

    typedef struct {
        logic [7:0] b;
        bit         good;
    } rx_t;
    rx_t rxq[$];

    always #5 clk = ~clk;
    always @(negedge clk) edge_n <= edge_n + 1;

    simplez_uart_tx #(
        .DATAW(12), .ADDRW(9), .BAUD_DIV(B), .ADDR_DATA(A_DATA), .ADDR_STAT(A_STAT)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr(wr), .din(din),
        .dout(dout), .sel(sel), .tx(tx), .busy(busy)
    );

    simplez_uart_tx #(
        .DATAW(12), .ADDRW(9), .BAUD_DIV(BF), .ADDR_DATA(A_DATA), .ADDR_STAT(A_STAT)
    ) dut_fast (
        .clk(clk), .rst(rst), .addr(addr2), .wr(wr2), .din(din2),
        .dout(dout2), .sel(sel2), .tx(tx2), .busy(busy2)
    );

    function automatic void model_reset();
        m_w.delete();
        m_l.delete();
        m_b.delete();
        m_ovr  = 1'b0;
        m_hold = 8'h00;
    endfunction

    // Accepted if the holding slot is empty or is emptied on this very edge;
    // a load needs the previous frame (10 bits) plus one idle edge.
    function automatic void model_write(input int w, input logic [7:0] v);
        int l;
        if (m_l.size() == 0 || m_l[$] <= w) begin
            l = w + 1;
            if (m_l.size() != 0 && m_l[$] + 10 * B + 1 > l) l = m_l[$] + 10 * B + 1;
            m_w.push_back(w);
            m_l.push_back(l);
            m_b.push_back(v);
            m_hold = v;
        end else begin
            m_ovr = 1'b1;
        end
    endfunction

    function automatic logic m_busy(input int e);
        foreach (m_l[i]) if (e >= m_l[i] && e < m_l[i] + 10 * B) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_full(input int e);
        foreach (m_l[i]) if (e >= m_w[i] && e < m_l[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_tx(input int e);
        int k;
        foreach (m_l[i]) begin
            if (e >= m_l[i] + 1 && e <= m_l[i] + 10 * B) begin
                k = (e - m_l[i] - 1) / B;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return m_b[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [11:0] m_stat(input int e);
        return {9'b0, m_ovr, m_busy(e), ~m_full(e)};
    endfunction

    task automatic drive_write(input logic [8:0] a, input logic [11:0] d);
        addr = a;
        din  = d;
        wr   = 1'b1;
        if (a == A_DATA) model_write(edge_n + 1, d[7:0]);
        else if (a == A_STAT) m_ovr = 1'b0;
        @(posedge clk);
        wr   = 1'b0;
        addr = A_STAT;
        din  = '0;
    endtask

    initial begin : rx_fast
        logic [9:0] fr;
        bit good, ab;
        rx_t r;
        forever begin
            @(posedge clk);
            if (rst !== 1'b1 && tx2 === 1'b0) begin
                fr   = '0;
                good = 1'b1;
                ab   = 1'b0;
                for (int n = 1; n < 10 * BF; n++) begin
                    @(posedge clk);
                    if (rst === 1'b1) begin
                        ab = 1'b1;
                        break;
                    end
                    if (n % BF == 0) fr[n/BF] = tx2;
                    else if (tx2 !== fr[n/BF]) good = 1'b0;
                end
                if (!ab) begin
                    r.b    = fr[8:1];
                    r.good = good && (fr[9] === 1'b1);
                    rxq.push_back(r);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; wr = 1'b0; addr = A_LEDS; din = '0;
        wr2 = 1'b0; addr2 = A_LEDS; din2 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (sel !== 1'b0) begin n_err++; $display("FAIL reset_sel_leds: got %b want 0", sel); end
        n_vec++; if (dout !== 12'h000) begin n_err++; $display("FAIL reset_dout_leds: got %h want 000", dout); end
        n_vec++; if (tx2 !== 1'b1) begin n_err++; $display("FAIL reset_tx_fast: got %b want 1", tx2); end
        addr = A_STAT;
        @(posedge clk);
        n_vec++; if (dout !== 12'h001) begin n_err++; $display("FAIL reset_stat: got %h want 001", dout); end
        n_vec++; if (sel !== 1'b1) begin n_err++; $display("FAIL reset_sel_stat: got %b want 1", sel); end
        addr = A_DATA;
        @(posedge clk);
        n_vec++; if (dout !== 12'h000) begin n_err++; $display("FAIL reset_hold: got %h want 000", dout); end
        rst = 1'b0;
        addr = A_STAT;
        @(posedge clk);
    endtask

    task automatic test_single();
        int w, e, busy_cnt, first_low;
        busy_cnt  = 0;
        first_low = -1;
        drive_write(A_DATA, 12'hF55);
        w = edge_n;
        for (int k = 0; k < 10 * B + 6; k++) begin
            @(posedge clk);
            e = edge_n;
            n_vec++; if (tx !== m_tx(e)) begin n_err++; $display("FAIL single_tx@%0d: got %b want %b", e - w, tx, m_tx(e)); end
            n_vec++; if (busy !== m_busy(e)) begin n_err++; $display("FAIL single_busy@%0d: got %b want %b", e - w, busy, m_busy(e)); end
            if (busy === 1'b1) busy_cnt++;
            if (tx === 1'b0 && first_low < 0) first_low = e - w;
        end
        n_vec++; if (busy_cnt != 40) begin n_err++; $display("FAIL single_busy_len: got %0d want 40", busy_cnt); end
        n_vec++; if (first_low != 2) begin n_err++; $display("FAIL single_latency: got %0d want 2", first_low); end
        addr = A_DATA;
        @(posedge clk);
        n_vec++; if (dout !== 12'h055) begin n_err++; $display("FAIL single_hold: got %h want 055", dout); end
        addr = A_STAT;
    endtask

    task automatic test_back_to_back();
        int e;
        drive_write(A_DATA, 12'h0A5);
        drive_write(A_DATA, 12'h03C);
        drive_write(A_DATA, 12'h077);
        @(posedge clk);
        n_vec++; if (dout !== 12'h006) begin n_err++; $display("FAIL overrun_stat: got %h want 006", dout); end
        drive_write(A_STAT, 12'hFFF);
        @(posedge clk);
        n_vec++; if (dout !== 12'h002) begin n_err++; $display("FAIL ovr_clear_stat: got %h want 002", dout); end
        for (int k = 0; k < 20 * B + 12; k++) begin
            @(posedge clk);
            e = edge_n;
            n_vec++; if (tx !== m_tx(e)) begin n_err++; $display("FAIL b2b_tx@%0d: got %b want %b", e, tx, m_tx(e)); end
            n_vec++; if (dout !== m_stat(e)) begin n_err++; $display("FAIL b2b_stat@%0d: got %h want %h", e, dout, m_stat(e)); end
        end
        addr = A_DATA;
        @(posedge clk);
        n_vec++; if (dout !== 12'h03C) begin n_err++; $display("FAIL b2b_hold: got %h want 03c", dout); end
        addr = A_STAT;
    endtask

    task automatic test_reset_mid();
        int l, target, e;
        drive_write(A_DATA, 12'h05A);
        l = m_l[$];
        drive_write(A_DATA, 12'h0C3);
        target = l + 1 + 4 * B + 1;
        for (int g = 0; g < 200 && edge_n < target; g++) begin
            @(posedge clk);
            e = edge_n;
            n_vec++; if (tx !== m_tx(e)) begin n_err++; $display("FAIL mid_tx@%0d: got %b want %b", e, tx, m_tx(e)); end
        end
        n_vec++; if (edge_n < target) begin n_err++; $display("FAIL mid_timeout: got edge %0d want %0d", edge_n, target); end
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx: got %b want 1", tx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_vec++; if (dout !== 12'h001) begin n_err++; $display("FAIL mid_rst_stat: got %h want 001", dout); end
        rst = 1'b0;
        for (int k = 0; k < 12 * B + 10; k++) begin
            @(posedge clk);
            n_vec++; if (tx !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL mid_after_rst: got tx=%b busy=%b want tx=1 busy=0", tx, busy); end
        end
    endtask

    task automatic test_random();
        int gap, e;
        for (int t = 0; t < 16; t++) begin
            gap = $urandom_range(0, 45);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                e = edge_n;
                n_vec++; if (tx !== m_tx(e)) begin n_err++; $display("FAIL rand_tx@%0d: got %b want %b", e, tx, m_tx(e)); end
                n_vec++; if (busy !== m_busy(e)) begin n_err++; $display("FAIL rand_busy@%0d: got %b want %b", e, busy, m_busy(e)); end
                n_vec++; if (dout !== m_stat(e)) begin n_err++; $display("FAIL rand_stat@%0d: got %h want %h", e, dout, m_stat(e)); end
            end
            if ($urandom_range(0, 5) == 0) drive_write(A_STAT, 12'($urandom));
            else drive_write(A_DATA, 12'($urandom));
        end
        for (int k = 0; k < 20 * B + 10; k++) begin
            @(posedge clk);
            e = edge_n;
            n_vec++; if (tx !== m_tx(e)) begin n_err++; $display("FAIL rand_drain_tx@%0d: got %b want %b", e, tx, m_tx(e)); end
            n_vec++; if (dout !== m_stat(e)) begin n_err++; $display("FAIL rand_drain_stat@%0d: got %h want %h", e, dout, m_stat(e)); end
        end
        addr = A_DATA;
        @(posedge clk);
        n_vec++; if (dout !== {4'h0, m_hold}) begin n_err++; $display("FAIL rand_hold: got %h want %h", dout, {4'h0, m_hold}); end
        addr = A_STAT;
    endtask

    task automatic test_fast();
        logic [7:0] v[3];
        rx_t r;
        v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'h80;
        rxq.delete();
        for (int i = 0; i < 3; i++) begin
            addr2 = A_DATA; din2 = {4'hA, v[i]}; wr2 = 1'b1;
            @(posedge clk);
            wr2 = 1'b0; addr2 = A_LEDS; din2 = '0;
            for (int g = 0; g < 11 * BF + 20 && rxq.size() == 0; g++) @(posedge clk);
            n_vec++;
            if (rxq.size() == 0) begin
                n_err++; $display("FAIL fast_timeout: got no frame want %h", v[i]);
            end else begin
                r = rxq.pop_front();
                if (r.b !== v[i]) begin n_err++; $display("FAIL fast_byte: got %h want %h", r.b, v[i]); end
                n_vec++; if (!r.good) begin n_err++; $display("FAIL fast_framing: got bad frame want clean for %h", v[i]); end
            end
        end
        repeat (2) @(posedge clk);
        n_vec++; if (tx2 !== 1'b1 || busy2 !== 1'b0) begin n_err++; $display("FAIL fast_idle: got tx=%b busy=%b want tx=1 busy=0", tx2, busy2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_fast();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
